// File: rtl/countone_deadlock_reporter_if.sv
// Report channel of the countone deadlock reporter: one valid/ready beat that carries
// the info snapshot and the start cycle of the deadlocked run.
interface countone_deadlock_reporter_if #(
    parameter int unsigned INFO_W = 1,
    parameter int unsigned CNT_W  = 32
);
    logic              rpt_valid;
    logic              rpt_ready;
    logic [INFO_W-1:0] rpt_info;
    logic [CNT_W-1:0]  rpt_cycle;

    modport master (
        output rpt_valid,
        input  rpt_ready,
        output rpt_info,
        output rpt_cycle
    );

    modport slave (
        input  rpt_valid,
        output rpt_ready,
        input  rpt_info,
        input  rpt_cycle
    );
endinterface

// File: rtl/countone_deadlock_reporter.sv
// Filters transient stalls from the countone monitor and emits one timestamped deadlock
// report per occurrence, holding a sticky deadlock flag until software clears it.
module countone_deadlock_reporter #(
    parameter int unsigned INFO_W    = 1,
    parameter int unsigned THRESHOLD = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        block,
    input  logic [INFO_W-1:0]           axis_block_info,
    input  logic                        clear,
    countone_deadlock_reporter_if.master rpt,
    output logic                        deadlock,
    output logic [1:0]                  state_dbg
);
    localparam int unsigned RUN_W = $clog2(THRESHOLD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        REPORT  = 2'd2,
        LATCHED = 2'd3
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  cyc_d;
    logic [CNT_W-1:0]  start_q;
    logic [RUN_W-1:0]  run_q;
    logic [RUN_W-1:0]  run_d;
    logic [INFO_W-1:0] snap_q;
    logic              rpt_valid_q;
    logic [INFO_W-1:0] rpt_info_q;
    logic [CNT_W-1:0]  rpt_cycle_q;
    logic              deadlock_q;

    always_comb begin
        cyc_d = cyc_q + CNT_W'(1);
        run_d = run_q + RUN_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            start_q     <= '0;
            run_q       <= '0;
            snap_q      <= '0;
            rpt_valid_q <= 1'b0;
            rpt_info_q  <= '0;
            rpt_cycle_q <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            // clear re-arms from any state; a block sampled on this edge is dropped
            if (clear) begin
                state_q     <= IDLE;
                run_q       <= '0;
                rpt_valid_q <= 1'b0;
                deadlock_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (block) begin
                            if (THRESHOLD == 1) begin
                                state_q     <= REPORT;
                                rpt_valid_q <= 1'b1;
                                rpt_info_q  <= axis_block_info;
                                rpt_cycle_q <= cyc_q;
                                deadlock_q  <= 1'b1;
                            end else begin
                                state_q <= ARMING;
                                run_q   <= RUN_W'(1);
                                snap_q  <= axis_block_info;
                                start_q <= cyc_q;
                            end
                        end
                    end
                    ARMING: begin
                        if (!block) begin
                            state_q <= IDLE;
                            run_q   <= '0;
                        end else if (axis_block_info != snap_q) begin
                            // different blocked channel: the run starts over here
                            run_q   <= RUN_W'(1);
                            snap_q  <= axis_block_info;
                            start_q <= cyc_q;
                        end else if (run_d == RUN_W'(THRESHOLD)) begin
                            state_q     <= REPORT;
                            run_q       <= '0;
                            rpt_valid_q <= 1'b1;
                            rpt_info_q  <= snap_q;
                            rpt_cycle_q <= start_q;
                            deadlock_q  <= 1'b1;
                        end else begin
                            run_q <= run_d;
                        end
                    end
                    REPORT: begin
                        if (rpt.rpt_ready) begin
                            state_q     <= LATCHED;
                            rpt_valid_q <= 1'b0;
                        end
                    end
                    LATCHED: begin
                        state_q <= LATCHED;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rpt.rpt_valid = rpt_valid_q;
    assign rpt.rpt_info  = rpt_info_q;
    assign rpt.rpt_cycle = rpt_cycle_q;
    assign deadlock      = deadlock_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_countone_deadlock_reporter.sv
// Randomized bench for the deadlock reporter: two instances (THRESHOLD=4 and THRESHOLD=1)
// checked every cycle against a sliding-window model of the deadlock rules.
module tb_countone_deadlock_reporter;
    logic       clock = 1'b0;
    logic       reset;
    logic       block;
    logic [1:0] info;
    logic       clear;
    logic       rdy;

    logic       d0_deadlock, d1_deadlock;
    logic [1:0] d0_state, d1_state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clock = ~clock;

    countone_deadlock_reporter_if #(.INFO_W(2), .CNT_W(8)) rpt0 ();
    countone_deadlock_reporter_if #(.INFO_W(1), .CNT_W(4)) rpt1 ();
    assign rpt0.rpt_ready = rdy;
    assign rpt1.rpt_ready = rdy;

    countone_deadlock_reporter #(.INFO_W(2), .THRESHOLD(4), .CNT_W(8)) dut0 (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (info),
        .clear           (clear),
        .rpt             (rpt0),
        .deadlock        (d0_deadlock),
        .state_dbg       (d0_state)
    );

    countone_deadlock_reporter #(.INFO_W(1), .THRESHOLD(1), .CNT_W(4)) dut1 (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_info (info[0]),
        .clear           (clear),
        .rpt             (rpt1),
        .deadlock        (d1_deadlock),
        .state_dbg       (d1_state)
    );

    // Model: a deadlock is the first moment the newest T samples are all blocked with
    // the same info; the report carries that info and the cycle of the oldest sample.
    logic [1:0] inf_h [2][4];
    logic [7:0] cyc_h [2][4];
    int unsigned nblk [2];
    logic       m_dl [2];
    logic       m_pend [2];
    logic       m_lastb [2];
    logic [7:0] m_cyc [2];
    logic [1:0] m_rinfo [2];
    logic [7:0] m_rcyc [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input int m, input logic r, input logic c, input logic b,
                              input logic [1:0] inf, input logic rd);
        int unsigned t;
        logic [1:0]  im;
        logic [7:0]  cm;
        logic [7:0]  oc;
        logic        hit;
        t  = (m == 0) ? 4 : 1;
        im = (m == 0) ? 2'b11 : 2'b01;
        cm = (m == 0) ? 8'hFF : 8'h0F;
        if (r) begin
            m_cyc[m] = '0; m_dl[m] = 1'b0; m_pend[m] = 1'b0; m_lastb[m] = 1'b0;
            nblk[m] = 0; m_rinfo[m] = '0; m_rcyc[m] = '0;
        end else begin
            oc = m_cyc[m];
            m_cyc[m] = (m_cyc[m] + 8'd1) & cm;
            if (c) begin
                m_dl[m] = 1'b0; m_pend[m] = 1'b0; m_lastb[m] = 1'b0; nblk[m] = 0;
            end else if (m_dl[m]) begin
                if (m_pend[m] && rd) m_pend[m] = 1'b0;
            end else begin
                m_lastb[m] = b;
                if (!b) nblk[m] = 0;
                else begin
                    for (int i = 3; i > 0; i--) begin
                        inf_h[m][i] = inf_h[m][i-1];
                        cyc_h[m][i] = cyc_h[m][i-1];
                    end
                    inf_h[m][0] = inf & im;
                    cyc_h[m][0] = oc;
                    if (nblk[m] < 4) nblk[m]++;
                end
                hit = (nblk[m] >= t);
                for (int i = 1; i < 4; i++)
                    if (i < t && inf_h[m][i] != inf_h[m][0]) hit = 1'b0;
                if (hit) begin
                    m_dl[m] = 1'b1; m_pend[m] = 1'b1;
                    m_rinfo[m] = inf_h[m][0];
                    m_rcyc[m]  = cyc_h[m][t-1];
                    nblk[m] = 0;
                end
            end
        end
    endtask

    function automatic logic [1:0] exp_state(input int m);
        if (m_dl[m]) return m_pend[m] ? 2'd2 : 2'd3;
        return m_lastb[m] ? 2'd1 : 2'd0;
    endfunction

    task automatic compare_all();
        check_eq("d0_state", d0_state, exp_state(0));
        check_eq("d0_deadlock", d0_deadlock, m_dl[0]);
        check_eq("d0_valid", rpt0.rpt_valid, m_pend[0]);
        if (m_pend[0]) begin
            check_eq("d0_info", rpt0.rpt_info, m_rinfo[0]);
            check_eq("d0_cycle", rpt0.rpt_cycle, m_rcyc[0]);
        end
        check_eq("d1_state", d1_state, exp_state(1));
        check_eq("d1_deadlock", d1_deadlock, m_dl[1]);
        check_eq("d1_valid", rpt1.rpt_valid, m_pend[1]);
        if (m_pend[1]) begin
            check_eq("d1_info", rpt1.rpt_info, m_rinfo[1]);
            check_eq("d1_cycle", rpt1.rpt_cycle, m_rcyc[1]);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic b,
                        input logic [1:0] inf, input logic rd);
        reset = r; clear = c; block = b; info = inf; rdy = rd;
        @(posedge clock);
        for (int m = 0; m < 2; m++) model_edge(m, r, c, b, inf, rd);
        @(negedge clock);
        compare_all();
    endtask

    initial begin
        logic [1:0] cur_inf;
        reset = 1'b1; clear = 1'b0; block = 1'b0; info = '0; rdy = 1'b0;
        for (int m = 0; m < 2; m++) begin
            nblk[m] = 0; m_dl[m] = 1'b0; m_pend[m] = 1'b0; m_lastb[m] = 1'b0;
            m_cyc[m] = '0; m_rinfo[m] = '0; m_rcyc[m] = '0;
            for (int i = 0; i < 4; i++) begin inf_h[m][i] = '0; cyc_h[m][i] = '0; end
        end
        @(negedge clock);
        step(1, 0, 0, 2'd0, 0);
        step(1, 0, 0, 2'd0, 0);
        check_eq("rst_valid", rpt0.rpt_valid, 1'b0);
        check_eq("rst_info", rpt0.rpt_info, 2'd0);
        check_eq("rst_cycle", rpt0.rpt_cycle, 8'd0);
        check_eq("rst_state", d0_state, 2'd0);

        // run sampled at cyc 10..13 reports start cycle 10
        repeat (10) step(0, 0, 0, 2'd0, 0);
        repeat (4) step(0, 0, 1, 2'd0, 0);
        check_eq("s1_valid", rpt0.rpt_valid, 1'b1);
        check_eq("s1_cycle", rpt0.rpt_cycle, 8'd10);
        check_eq("s1_info", rpt0.rpt_info, 2'd0);
        check_eq("s1_deadlock", d0_deadlock, 1'b1);
        check_eq("s1_state", d0_state, 2'd2);

        // back-pressure, then handshake, then block activity is ignored
        for (int i = 0; i < 5; i++) step(0, 0, i[0], 2'd3, 0);
        step(0, 0, 1, 2'd0, 1);
        check_eq("hs_valid", rpt0.rpt_valid, 1'b0);
        check_eq("hs_state", d0_state, 2'd3);
        repeat (6) step(0, 0, 1, 2'd0, 0);
        check_eq("latched_state", d0_state, 2'd3);
        check_eq("latched_deadlock", d0_deadlock, 1'b1);

        // transient burst of 3 then a real run of 4
        step(0, 1, 0, 2'd0, 0);
        repeat (3) step(0, 0, 1, 2'd2, 0);
        step(0, 0, 0, 2'd2, 0);
        repeat (4) step(0, 0, 1, 2'd2, 0);
        step(0, 0, 0, 2'd0, 1);

        // info change on the second cycle restarts the run
        step(0, 1, 0, 2'd0, 0);
        step(0, 0, 1, 2'd1, 0);
        repeat (4) step(0, 0, 1, 2'd2, 0);
        check_eq("chg_info", rpt0.rpt_info, 2'd2);

        // clear and ready on the same edge: clear wins, block on that edge dropped
        step(0, 1, 1, 2'd2, 1);
        check_eq("clr_state", d0_state, 2'd0);
        check_eq("clr_deadlock", d0_deadlock, 1'b0);
        check_eq("clr_valid", rpt0.rpt_valid, 1'b0);

        // reset mid-report aborts everything
        repeat (4) step(0, 0, 1, 2'd1, 0);
        step(1, 0, 1, 2'd1, 1);
        check_eq("rr_valid", rpt0.rpt_valid, 1'b0);
        check_eq("rr_state", d0_state, 2'd0);
        check_eq("rr_cycle", rpt0.rpt_cycle, 8'd0);
        step(0, 0, 1, 2'd1, 0);
        check_eq("rr_d1_cycle", rpt1.rpt_cycle, 4'd0);

        cur_inf = 2'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) cur_inf = 2'($urandom_range(0, 3));
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 9) < 8), cur_inf, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/countone_deadlock_reporter.md
Name: countone_deadlock_reporter

Overview:
Consumer side of the countone HLS deadlock monitor. It takes the monitor's `block` flag and per-AXIS block info, and filters out transient stalls by requiring `block` to persist for THRESHOLD consecutive cycles. It then emits exactly one timestamped deadlock report over a valid/ready channel and holds a sticky deadlock flag until software clears it. It sits beside the countone instance in the PYNQ design, feeding a debug register or AXI-Lite status block.

Parameters:
- INFO_W, 1: width of `axis_block_info` and `rpt_info`.
- THRESHOLD, 16: consecutive sampled-`block` cycles required to declare deadlock. Must be >= 1.
- CNT_W, 32: width of the free-running cycle counter and of `rpt_cycle`.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `block`  in  1  monitor block indication.
- `axis_block_info`  in  INFO_W  monitor per-AXIS block info; valid while `block`=1.
- `clear`  in  1  single-cycle pulse; re-arms the reporter.
- `rpt_valid`  out  1  report available.
- `rpt_ready`  in  1  report accepted when `rpt_valid` & `rpt_ready`.
- `rpt_info`  out  INFO_W  info snapshot of the deadlocked run.
- `rpt_cycle`  out  CNT_W  cycle-counter value at the first cycle of the deadlocked run.
- `deadlock`  out  1  sticky deadlock flag.
- `state_dbg`  out  2  current state encoding: IDLE=0, ARMING=1, REPORT=2, LATCHED=3.

Behaviour:
- Reset: all registers are synchronous-reset.
  - State = IDLE.
  - `rpt_valid` = 0, `deadlock` = 0, `rpt_info` = 0, `rpt_cycle` = 0, `state_dbg` = 0.
  - Cycle counter `cyc` = 0; run counter = 0; snapshot = 0.
  - Reset asserted in any state, including REPORT with a pending handshake, aborts everything on that edge.
- `cyc`: increments by 1 on every non-reset edge and wraps modulo 2^CNT_W. `rpt_cycle` captures the pre-increment value.
- Run counter: width clog2(THRESHOLD+1); counts consecutive sampled-high `block` cycles.
- IDLE:
  - `block`=1 sampled with THRESHOLD=1: go directly to REPORT.
  - `block`=1 sampled otherwise: go to ARMING with run=1, snapshot=`axis_block_info`, start=`cyc`.
- ARMING:
  - `block`=0: go to IDLE, run=0.
  - `block`=1 and `axis_block_info` != snapshot: stay in ARMING, run=1, snapshot=new info, start=`cyc` (run restarts).
  - `block`=1 and info unchanged with run+1 == THRESHOLD: go to REPORT.
  - Otherwise: run += 1.
- Entering REPORT:
  - `rpt_valid`=1, `rpt_info`=snapshot (or the current info for the direct THRESHOLD=1 path), `rpt_cycle`=start, `deadlock`=1.
- Report latency: if `block` is sampled high at edges k..k+THRESHOLD-1 with constant info, `rpt_valid` rises immediately after edge k+THRESHOLD-1.
- REPORT:
  - `rpt_valid`, `rpt_info` and `rpt_cycle` are held stable until `rpt_ready`=1 is sampled; then go to LATCHED with `rpt_valid`=0.
  - `block` is ignored in this state.
  - `rpt_ready`=1 outside REPORT has no effect.
- LATCHED: `deadlock` stays 1; no new report is generated regardless of `block`.
- `clear` (priority over every other input except reset):
  - From any state go to IDLE; `deadlock`=0, `rpt_valid`=0, run=0.
  - `clear` in REPORT withdraws an unaccepted report. This is the only permitted valid-drop.
  - `clear` and `rpt_ready` on the same edge: `clear` wins and no handshake is counted.
  - A `block`=1 on the clearing edge is not counted; arming starts from the next edge.
- `deadlock` equals 1 exactly in the REPORT and LATCHED states.
- `cyc` wrap during a run is harmless: `rpt_cycle` is the raw start value.

Test Plan:
- THRESHOLD=4, reset, then `block`=1 with info=0 sampled at `cyc`=10..13 -> `rpt_valid`=1 after the `cyc`=13 edge, `rpt_cycle`=10, `rpt_info`=0, `deadlock`=1, `state_dbg`=2.
- THRESHOLD=4, `block` high for 3 cycles, low for 1, then high for 4 starting at `cyc`=20 -> no report from the first burst; report with `rpt_cycle`=20.
- THRESHOLD=4, `rpt_ready`=0 for 5 cycles then 1 -> outputs stable for all 5 cycles; after the handshake `rpt_valid`=0, `state_dbg`=3, `deadlock`=1; further `block` activity gives no new report.
- INFO_W=2, info changes 2'b01 to 2'b10 on the second cycle of a run that started at `cyc`=30 -> report `rpt_info`=2'b10, `rpt_cycle`=31.
- `clear` while in REPORT with `rpt_ready`=1 on the same edge -> `rpt_valid`=0, `deadlock`=0, `state_dbg`=0 next cycle; `block`=1 on that edge is ignored.
- THRESHOLD=1, single-cycle `block` pulse at `cyc`=5 -> `rpt_valid` next cycle with `rpt_cycle`=5; then reset asserted mid-REPORT -> all outputs 0 and `cyc`=0 after that edge.
